cdc_handshake_sender: RTL and testbench
=======================================

Name: cdc_handshake_sender

Overview:
- Source-domain end of a two-phase (toggle) bus handshake across a clock-domain boundary.
- Accepts a WIDTH-bit word over valid/ready and holds it stable on xfer_data.
- Toggles xfer_req, then waits for the destination's xfer_ack toggle, which it synchronises locally through SYNC_STAGES flops.
- Pairs with a destination-side block that multi-flop synchronises xfer_req and samples xfer_data once the toggle is seen.

Parameters:
WIDTH, 8, data word width in bits (>=1)
SYNC_STAGES, 2, flops in the xfer_ack synchroniser chain (>=2)
TIMEOUT_CYCLES, 0, WAIT cycles before timeout_err sets; 0 disables the timeout

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low; asserts asynchronously, deasserts synchronously to clk
in_valid  input  1  source word valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  source word
xfer_data  output  WIDTH  registered word, stable from the req toggle until the matching ack
xfer_req  output  1  request toggle level, registered
xfer_ack  input  1  acknowledge toggle from destination domain, asynchronous to clk
done  output  1  one-cycle pulse when a transfer completes
busy  output  1  high while in WAIT
timeout_err  output  1  sticky: ack not seen within TIMEOUT_CYCLES
proto_err  output  1  sticky: ack toggled while no request is outstanding
err_clear  input  1  synchronous clear of both sticky errors

Behaviour:
- Reset values (rst low): xfer_data=0, xfer_req=0, all ack sync flops=0, done=0, busy=0, timeout_err=0, proto_err=0, wait counter=0, state IDLE.
- in_ready = (state==IDLE), combinational from the state register. in_ready is 0 while rst is low.
- ack_s is the last flop of the xfer_ack synchroniser. xfer_ack must never feed any other logic.
- IDLE:
  - On an edge with in_valid & in_ready: xfer_data <= in_data, xfer_req <= ~xfer_req, counter <= 0, go to WAIT.
  - No other signal changes on that edge.
- WAIT:
  - in_ready=0 and busy=1; in_data and in_valid are ignored.
  - xfer_data and xfer_req hold.
  - Counter increments, saturating.
  - On an edge where ack_s == xfer_req: go to IDLE and done <= 1 for exactly one cycle. in_ready rises in that same cycle.
- Back-to-back transfers: a word offered during the done cycle is accepted on that edge, giving a minimum spacing of 1 + round-trip cycles.
- Latency: xfer_req toggles 1 edge after acceptance. done asserts SYNC_STAGES+1 edges after xfer_ack toggles, counting the edge that samples it.
- Timeout (TIMEOUT_CYCLES>0):
  - When counter reaches TIMEOUT_CYCLES in WAIT, timeout_err <= 1.
  - The state stays WAIT: the transfer is never abandoned, to keep toggle parity.
  - A late ack still completes normally.
- Protocol error: in IDLE, ack_s != xfer_req sets proto_err <= 1. State is unaffected.
- Sticky errors:
  - err_clear clears both flags on the next edge.
  - If err_clear and a set condition occur on the same edge, set wins.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.
- Reset mid-transfer: everything returns to reset values. The destination end must be reset together with this block.
- done is 0 whenever state is IDLE and no completion occurred on the preceding edge.

Test Plan:
- Reset:
  - Stimulus: hold rst low with in_valid=1 and xfer_ack toggling.
  - Response: in_ready=0, xfer_req=0, xfer_data=0, done=0, no errors.
  - After release: in_ready=1.
- Single transfer (loopback model: ack = req delayed 3 cycles, SYNC_STAGES=2):
  - Stimulus: in_data=8'hA5, in_valid=1 for one cycle.
  - Response: next cycle xfer_req=1 and xfer_data=A5.
  - xfer_data remains A5 even if in_data changes.
  - done pulses exactly 1 cycle, 6 cycles after the req toggle.
  - busy is high throughout.
- Back-to-back:
  - Stimulus: in_valid held high with words 01, 02, 03.
  - Response: three done pulses; xfer_req sequence 1, 0, 1.
  - Each word is presented in order, and acceptance happens only in the done cycle or in IDLE.
- Timeout (TIMEOUT_CYCLES=10):
  - Stimulus: accept word 3C; hold xfer_ack constant for 20 cycles; then toggle ack.
  - Response: timeout_err=1 at wait count 10, busy stays 1.
  - After the late ack: done pulses and timeout_err stays 1.
  - Asserting err_clear then clears timeout_err.
- Protocol error:
  - Stimulus: in IDLE, toggle xfer_ack with no request outstanding.
  - Response: proto_err=1 after SYNC_STAGES+1 edges.
  - Asserting err_clear on the same edge as a fresh violation leaves proto_err=1.
- Reset mid-WAIT:
  - Stimulus: assert rst 2 cycles after acceptance.
  - Response: immediate xfer_req=0, busy=0, no done pulse.
  - After release: a new transfer of word 5A completes normally.

Source files
------------

// File: rtl/cdc_handshake_sender.sv
// cdc_handshake_sender: source end of a two-phase toggle handshake, holds a word on xfer_data until the ack toggle returns
module cdc_handshake_sender #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack,
  output logic             done,
  output logic             busy,
  output logic             timeout_err,
  output logic             proto_err,
  input  logic             err_clear
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ack_s, accept, complete, to_set, pe_set;
  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign in_ready = rst & (state_q == IDLE);
  assign busy     = state_q == WAIT;
  assign accept   = in_valid & in_ready;
  assign complete = busy & (ack_s == xfer_req);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_set  = 1'b0;
    pe_set  = 1'b0;
    if (state_q == IDLE) begin
      state_d = accept ? WAIT : IDLE;
      cnt_d   = accept ? '0 : cnt_q;
      pe_set  = ack_s != xfer_req;
    end else begin
      state_d = complete ? IDLE : WAIT;
      cnt_d   = cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
      to_set  = (TIMEOUT_CYCLES > 0) && (cnt_d == CMAX);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // xfer_ack is only ever seen through this chain
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ack_sync    <= '0;
      cnt_q       <= '0;
      xfer_data   <= '0;
      xfer_req    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      ack_sync    <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
      cnt_q       <= cnt_d;
      done        <= complete;
      timeout_err <= to_set | (timeout_err & ~err_clear);
      proto_err   <= pe_set | (proto_err & ~err_clear);
      if (accept) begin
        xfer_data <= in_data;
        xfer_req  <= ~xfer_req;
      end
    end
endmodule

// File: tb/tb_cdc_handshake_sender.sv
// tb_cdc_handshake_sender: directed and random checks against a fixed-round-trip transfer model
module tb_cdc_handshake_sender;
  logic clk = 0, rst = 0, in_valid = 0, err_clear = 0, man_ack = 0, loop_en = 0;
  logic [7:0] in_data = 0, xfer_data;
  logic in_ready, xfer_req, xfer_ack, done, busy, timeout_err, proto_err;
  logic [2:0] pipe;
  int checks = 0, failures = 0, dones = 0, d0, idx;
  logic m_ready = 1, m_req = 0, m_done = 0, m_terr = 0, m_perr = 0, acc;
  logic [7:0] m_data = 0;
  int m_left = 0;
  logic [7:0] words [3];
  logic reqseq [3];

  cdc_handshake_sender #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .xfer_data(xfer_data), .xfer_req(xfer_req), .xfer_ack(xfer_ack), .done(done),
    .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;
  // destination stand-in: ack is req delayed three cycles, reset with the sender
  always @(posedge clk or negedge rst)
    if (!rst) pipe <= '0;
    else pipe <= {pipe[1:0], xfer_req};
  assign xfer_ack = loop_en ? pipe[2] : man_ack;
  always @(negedge clk) if (done) dones++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ready = 1; m_req = 0; m_data = 0; m_done = 0; m_left = 0; m_terr = 0; m_perr = 0;
  endtask

  // loopback round trip: 3 cycles of delay + 2 sync flops + 1 completion edge
  task automatic run_cycle(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    tick();
    if (m_ready && v) begin
      m_ready = 0; m_req = ~m_req; m_data = d; m_left = 6; m_done = 0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin m_ready = 1; m_done = 1; end
    end else m_done = 0;
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, !m_ready);
    chk("done", done, m_done);
    chk("xfer_req", xfer_req, m_req);
    chk("xfer_data", xfer_data, m_data);
    chk("timeout_err", timeout_err, m_terr);
    chk("proto_err", proto_err, m_perr);
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    tick();
    rst = 1;
    model_reset();
  endtask

  initial begin
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      man_ack = ~man_ack;
      tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_req", xfer_req, 0);
      chk("rst_data", xfer_data, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_perr", proto_err, 0);
    end
    in_valid = 0;
    man_ack  = 0;
    loop_en  = 1;
    rst      = 1;
    #1;
    chk("rel_ready", in_ready, 1);

    d0 = dones;
    run_cycle(1, 8'hA5);
    for (int i = 0; i < 8; i++) run_cycle(0, 8'($urandom));
    chk("single_done_cnt", dones - d0, 1);

    do_reset();
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    idx = 0;
    d0 = dones;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      acc = m_ready;
      run_cycle(1, words[idx]);
      if (acc) begin reqseq[idx] = xfer_req; idx++; end
    end
    chk("b2b_accepted", idx, 3);
    for (int i = 0; i < 7; i++) run_cycle(0, 8'h00);
    chk("b2b_req0", reqseq[0], 1);
    chk("b2b_req1", reqseq[1], 0);
    chk("b2b_req2", reqseq[2], 1);
    chk("b2b_done_cnt", dones - d0, 3);

    for (int i = 0; i < 300; i++) run_cycle(1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < 8; i++) run_cycle(0, 8'h00);

    man_ack  = m_req;
    loop_en  = 0;
    in_valid = 1;
    in_data  = 8'h3C;
    tick();
    in_valid = 0;
    m_req = ~m_req;
    chk("to_req", xfer_req, m_req);
    chk("to_data", xfer_data, 8'h3C);
    for (int k = 1; k <= 20; k++) begin
      in_data = 8'($urandom);
      tick();
      chk("to_err", timeout_err, k >= 10);
      chk("to_busy", busy, 1);
      chk("to_done", done, 0);
      chk("to_hold", xfer_data, 8'h3C);
    end
    man_ack = m_req;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("late_done", done, k == 3);
      chk("late_busy", busy, k < 3);
      chk("late_terr", timeout_err, 1);
    end
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("terr_clear", timeout_err, 0);

    man_ack = ~m_req;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("perr_set", proto_err, k == 3);
      chk("perr_ready", in_ready, 1);
    end
    err_clear = 1;
    man_ack   = m_req;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("perr_clear", proto_err, k < 3);
    end
    err_clear = 0;

    loop_en = 1;
    m_data  = 8'h3C;
    run_cycle(1, 8'h77);
    run_cycle(0, 8'h00);
    run_cycle(0, 8'h00);
    d0  = dones;
    rst = 0;
    #1;
    chk("mid_req", xfer_req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", in_ready, 0);
    chk("mid_data", xfer_data, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("mid_done", done, 0);
    end
    rst = 1;
    model_reset();
    run_cycle(1, 8'h5A);
    for (int i = 0; i < 8; i++) run_cycle(0, 8'($urandom));
    chk("mid_done_cnt", dones - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
